// File: rtl/division_pkg.sv
// Shared definitions for the restoring-division controller and its datapath.
package division_pkg;

    localparam int N_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_STEP = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/module_cociente.sv
// Quotient-bit register: each enable pulse writes ~signo into q[indice].
// Deliberately without reset; every valid run rewrites all N bits.
module module_cociente
    import division_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 enable,
    input  logic                 signo,
    input  logic [$clog2(N)-1:0] indice,
    output logic [N-1:0]         q
);

    logic [N-1:0] r_q;

    // Capture one quotient bit per enable pulse.
    always_ff @(posedge clk) begin
        if (enable) begin
            r_q[indice] <= ~signo;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/module_restador.sv
// Combinational trial subtractor: D = {0,R'} - {0,B} on N+1 bits.
// o_diff carries the low N bits of D, o_neg its sign bit D[N].
module module_restador
    import division_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] i_r,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_diff,
    output logic         o_neg
);

    logic [N:0] w_d;

    assign w_d    = {1'b0, i_r} - {1'b0, i_b};
    assign o_diff = w_d[N-1:0];
    assign o_neg  = w_d[N];

endmodule

// File: rtl/module_division_ctrl.sv
// Restoring-division controller: one MSB-first restoring step per clock.
// Each step emits a registered enable pulse with the trial-subtraction sign
// and the quotient bit position; the final remainder is held on residuo.
module module_division_ctrl
    import division_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [N-1:0]         dividendo,
    input  logic [N-1:0]         divisor,
    output logic                 enable,
    output logic                 signo,
    output logic [$clog2(N)-1:0] indice,
    output logic [N-1:0]         residuo,
    output logic                 busy,
    output logic                 done,
    output logic                 div_zero
);

    localparam int IW = $clog2(N);

    state_t        r_state;
    state_t        w_next;
    logic          w_accept;
    logic          w_step;
    logic          w_last;
    logic          w_finish;
    logic          w_zero;

    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_rem;
    logic [IW-1:0] r_k;

    logic [IW-1:0] w_bitpos;
    logic [N-1:0]  w_rshift;
    logic [N-1:0]  w_diff;
    logic          w_neg;
    logic [N-1:0]  w_rem_next;

    logic          r_enable;
    logic          r_signo;
    logic [IW-1:0] r_indice;
    logic [N-1:0]  r_residuo;
    logic          r_busy;
    logic          r_done;
    logic          r_div_zero;

    assign w_zero     = (divisor == '0);
    assign w_bitpos   = IW'(N - 1) - r_k;
    // Shift the next dividend bit (MSB first) into the partial remainder.
    assign w_rshift   = {r_rem[N-2:0], r_a[w_bitpos]};
    // Restore (keep R') when the trial subtraction went negative.
    assign w_rem_next = w_neg ? w_rshift : w_diff;

    module_restador #(.N(N)) u_restador (
        .i_r    (w_rshift),
        .i_b    (r_b),
        .o_diff (w_diff),
        .o_neg  (w_neg)
    );

    // State register; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_last   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? S_DONE : S_STEP;
                end
            end
            S_STEP: begin
                w_step = 1'b1;
                if (r_k == IW'(N - 1)) begin
                    w_last = 1'b1;
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_finish = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latches and partial remainder; always reinitialised on accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a   <= dividendo;
            r_b   <= divisor;
            r_rem <= '0;
        end else if (w_step) begin
            r_rem <= w_rem_next;
        end
    end

    // Step counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k        <= '0;
            r_enable   <= 1'b0;
            r_signo    <= 1'b0;
            r_indice   <= '0;
            r_residuo  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            r_done   <= 1'b0;
            if (w_accept) begin
                r_k        <= '0;
                r_busy     <= 1'b1;
                r_div_zero <= w_zero;
                r_residuo  <= w_zero ? dividendo : '0;
            end
            if (w_step) begin
                r_enable <= 1'b1;
                r_signo  <= w_neg;
                r_indice <= w_bitpos;
                r_k      <= r_k + IW'(1);
                if (w_last) begin
                    r_residuo <= w_rem_next;
                end
            end
            if (w_finish) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign enable   = r_enable;
    assign signo    = r_signo;
    assign indice   = r_indice;
    assign residuo  = r_residuo;
    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_module_division_ctrl.sv
// Bench for module_division_ctrl driving module_cociente to capture Q.
module tb_module_division_ctrl;

    localparam int N  = 4;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  dividendo;
    logic [N-1:0]  divisor;
    logic          enable;
    logic          signo;
    logic [IW-1:0] indice;
    logic [N-1:0]  residuo;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [N-1:0]  q;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    module_division_ctrl #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividendo (dividendo),
        .divisor   (divisor),
        .enable    (enable),
        .signo     (signo),
        .indice    (indice),
        .residuo   (residuo),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    module_cociente #(.N(N)) u_cociente (
        .clk    (clk),
        .enable (enable),
        .signo  (signo),
        .indice (indice),
        .q      (q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One division, checked against plain integer arithmetic.
    task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input bit glitch);
        logic [N-1:0] eq;
        logic [N-1:0] er;
        int pulses;
        int done_at;
        eq = (b == 0) ? '0 : a / b;
        er = (b == 0) ? a : a % b;
        @(negedge clk);
        start = 1'b1; dividendo = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividendo = N'($urandom); divisor = N'($urandom);
        chk("busy_acc", busy, 1);
        pulses  = 0;
        done_at = -1;
        for (int e = 1; e <= N + 4; e++) begin
            @(posedge clk); #1;
            if (glitch && e == 2) begin
                start = 1'b1; dividendo = 4'd7; divisor = 4'd2;
            end
            if (glitch && e == 3) start = 1'b0;
            if (enable) begin
                if (pulses < N) begin
                    chk("indice", indice, N - 1 - pulses);
                    chk("signo", signo, !eq[N-1-pulses]);
                end
                pulses++;
            end
            if (done) begin
                done_at = e;
                break;
            end
        end
        start = 1'b0;
        chk("pulses", pulses, (b == 0) ? 0 : N);
        chk("latency", done_at, (b == 0) ? 1 : N + 1);
        chk("residuo", residuo, er);
        chk("div_zero", div_zero, (b == 0) ? 1 : 0);
        if (b != 0) chk("quotient", q, eq);
        @(posedge clk); #1;
        chk("done_width", done, 0);
        chk("busy_idle", busy, 0);
        chk("enable_idle", enable, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int prev_done;
        int dq[$];

        rst_n = 1'b0; start = 1'b0; dividendo = '0; divisor = '0;
        #1;
        chk("rst_outs", {enable, signo, indice, residuo, busy, done, div_zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_outs", {enable, signo, indice, residuo, busy, done, div_zero}, 0);

        run(4'd13, 4'd3, 1'b0);
        run(4'd15, 4'd1, 1'b0);
        run(4'd2,  4'd5, 1'b0);
        run(4'd9,  4'd0, 1'b0);
        run(4'd13, 4'd3, 1'b1);

        // Abort after the second enable pulse.
        @(negedge clk);
        start = 1'b1; dividendo = 4'd13; divisor = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        pulses = 0;
        for (int e = 0; e < N + 2 && pulses < 2; e++) begin
            @(posedge clk); #1;
            if (enable) pulses++;
        end
        chk("abort_pulses", pulses, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outs", {enable, signo, indice, residuo, busy, done, div_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(4'd6, 4'd2, 1'b0);

        // start held high: runs repeat every N+2 edges.
        @(negedge clk);
        start = 1'b1; dividendo = 4'd11; divisor = 4'd2;
        prev_done = 0;
        for (int e = 0; e <= 3 * (N + 2); e++) begin
            @(posedge clk); #1;
            if (done) begin
                dq.push_back(e);
                chk("b2b_width", prev_done, 0);
                chk("b2b_res", residuo, 1);
                chk("b2b_q", q, 5);
            end
            prev_done = int'(done);
        end
        start = 1'b0;
        chk("b2b_count", dq.size(), 3);
        if (dq.size() == 3) begin
            chk("b2b_first", dq[0], N + 1);
            chk("b2b_gap1", dq[1] - dq[0], N + 2);
            chk("b2b_gap2", dq[2] - dq[1], N + 2);
        end
        repeat (N + 4) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            run(N'($urandom), N'($urandom_range(0, 15)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
